// File: rtl/seq_pkg.sv
// Shared definitions for the serial frame transmitter: FSM states and the sync preamble.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        GAP
    } seq_state_t;

    localparam int SEQ_PRE_W = 4;
    localparam logic [SEQ_PRE_W-1:0] SEQ_PREAMBLE = 4'b1011;

endpackage

// File: rtl/seq_stuff_tracker.sv
// Remembers the last three bits put on the line during frames and flags when the
// next payload slot must carry a stuff 0 to stop the preamble reappearing.
module seq_stuff_tracker (
    input  logic clock,
    input  logic reset,
    input  logic drive_en,
    input  logic drive_bit,
    output logic insert
);

    logic [2:0] history;

    // Gap and idle zeros are not recorded, so history survives between frames.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            history <= 3'b000;
        end else if (drive_en) begin
            history <= {history[1:0], drive_bit};
        end
    end

    assign insert = (history == 3'b101);

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble 1011, payload MSB-first, then GAP_CYCLES zeros.
// Define SEQ_FRAME_TX_STUFF_EN to enable zero-stuffing of the payload.
module seq_frame_tx
    import seq_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              sequence_out,
    output logic              frame_active,
    output logic              stuffed_bit,
    output logic              done,
    output seq_state_t        fsm_state
);

    // Handshake: a word is taken on any rising edge where data_valid && data_ready;
    // data_ready is high only in IDLE, and data_in is not looked at afterwards.

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES);
    localparam logic [1:0]       PRE_LAST = 2'(SEQ_PRE_W - 1);

    seq_state_t        state;
    logic [DATA_W-1:0] shift_reg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [1:0]        pre_cnt;
    logic [1:0]        pre_next;
    logic              payload_done;
    logic              stuff_req;
    logic              drive_bit;

    assign pre_next     = pre_cnt + 2'd1;
    assign payload_done = (bit_cnt == LAST_BIT);
    assign fsm_state    = state;

`ifdef SEQ_FRAME_TX_STUFF_EN
    logic drive_en;

    assign drive_en = (state == IDLE) ? data_valid
                    : (state == PREAMBLE) || (state == PAYLOAD && !payload_done);

    seq_stuff_tracker u_stuff_tracker (
        .clock     (clock),
        .reset     (reset),
        .drive_en  (drive_en),
        .drive_bit (drive_bit),
        .insert    (stuff_req)
    );
`else
    assign stuff_req = 1'b0;
`endif

    // Bit to place on the line for the next cycle; shared by the FSM and the tracker.
    always_comb begin
        drive_bit = 1'b0;
        case (state)
            IDLE:     drive_bit = data_valid & SEQ_PREAMBLE[SEQ_PRE_W-1];
            PREAMBLE: drive_bit = (pre_cnt == PRE_LAST) ? shift_reg[DATA_W-1]
                                                        : SEQ_PREAMBLE[~pre_next];
            PAYLOAD:  drive_bit = !payload_done && !stuff_req && shift_reg[DATA_W-1];
            default:  drive_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            pre_cnt      <= 2'd0;
            sequence_out <= 1'b0;
            frame_active <= 1'b0;
            stuffed_bit  <= 1'b0;
            done         <= 1'b0;
            data_ready   <= 1'b1;
        end else begin
            sequence_out <= drive_bit;
            stuffed_bit  <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_valid) begin
                        shift_reg    <= data_in;
                        bit_cnt      <= '0;
                        pre_cnt      <= 2'd0;
                        frame_active <= 1'b1;
                        data_ready   <= 1'b0;
                        state        <= PREAMBLE;
                    end
                end
                PREAMBLE: begin
                    pre_cnt <= pre_next;
                    // The first payload bit goes out straight after the last preamble bit.
                    if (pre_cnt == PRE_LAST) begin
                        shift_reg <= shift_reg << 1;
                        bit_cnt   <= CNT_W'(1);
                        state     <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (payload_done) begin
                        frame_active <= 1'b0;
                        done         <= 1'b1;
                        gap_cnt      <= GAP_W'(1);
                        state        <= GAP;
                    end else if (stuff_req) begin
                        stuffed_bit <= 1'b1;
                    end else begin
                        shift_reg <= shift_reg << 1;
                        bit_cnt   <= bit_cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == LAST_GAP) begin
                        data_ready <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_frame_tx.md
# seq_frame_tx

Serial frame transmitter that produces the bit stream our Moore sequence detectors consume. It accepts a parallel payload word over a valid/ready handshake and drives it one bit per clock on `sequence_out`. Each frame is the sync preamble 1011, then the payload MSB-first, then an inter-frame gap of zeros. An optional bit-stuffing stage ensures the payload can never reproduce the preamble on the line.

## Interface
- `DATA_W`, default 8: payload width in bits; must be at least 1.
- `GAP_CYCLES`, default 2: zero bits driven after each payload; must be at least 1.
- `clock` input 1: clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `data_in` input DATA_W: payload word; sampled only on the accepting edge.
- `data_valid` input 1: payload word offered.
- `data_ready` output 1: transmitter can accept a word.
- `sequence_out` output 1: serial line, registered.
- `frame_active` output 1: high while preamble or payload bits are on the line.
- `stuffed_bit` output 1: high while `sequence_out` carries an inserted stuff bit.
- `done` output 1: one-cycle pulse marking the end of the payload.

## Operation
- States: IDLE, PREAMBLE, PAYLOAD, GAP. All outputs are registered (Moore).
- IDLE
  - `data_ready`=1 and `sequence_out`=0.
  - On an edge with `data_valid`&&`data_ready` (the accepting edge):
    - load `data_in` into the shift register;
    - clear the bit counter;
    - go to PREAMBLE.
- PREAMBLE
  - Drives 1, 0, 1, 1 over 4 cycles.
  - Then goes to PAYLOAD.
- PAYLOAD
  - Drives shift register MSB-first, one bit per cycle.
  - The bit counter (width $clog2(DATA_W+1)) counts payload bits only; stuff bits are not counted.
  - After DATA_W payload bits, goes to GAP.
- GAP
  - Drives 0 for GAP_CYCLES cycles.
  - `done`=1 in the first GAP cycle only.
  - Then returns to IDLE.
- `data_ready` is high only in IDLE. `data_valid` outside IDLE is ignored, and `data_in` may change freely after the accepting edge.
- `frame_active`=1 exactly during PREAMBLE and PAYLOAD cycles, including stuff-bit cycles.
- Reset, including mid-frame:
  - state IDLE; counter and history cleared;
  - `sequence_out`=0, `frame_active`=0, `stuffed_bit`=0, `done`=0;
  - `data_ready`=1 once reset deasserts;
  - an aborted frame produces no `done`.

## Timing
- Accepting edge at edge k: the first preamble bit is on `sequence_out` in the cycle after edge k.
- Frame length:
  - PRE_W+DATA_W cycles without stuffing;
  - plus 1 cycle per inserted stuff bit with stuffing.
- `done` is asserted in the cycle immediately after the last payload bit.
- Back-to-back frames with `data_valid` held high:
  - the next accept occurs on the edge ending the first IDLE cycle;
  - minimum preamble-start spacing = 1 + 4 + DATA_W + GAP_CYCLES (+ stuffs) cycles.
- The line never carries 1011 spanning the gap→preamble boundary, because the gap and idle bits are 0.

## Configuration
- Macro: `SEQ_FRAME_TX_STUFF_EN`.
- Defined:
  - A 3-bit history holds the last three bits actually driven: preamble, payload and stuff bits.
  - In PAYLOAD, if the history equals 101 and payload bits remain, the next cycle drives a stuff bit 0 with `stuffed_bit`=1.
    - The shift register and counter hold during that cycle.
  - No stuff bit is inserted after the final payload bit; the gap zeros serve instead.
  - The history is cleared on reset and not cleared between frames.
- Undefined:
  - The payload is sent raw, and `stuffed_bit` is tied to 0.
  - The port list is unchanged.

## Structure
- Shared package `seq_pkg` holds:
  - the state enum (IDLE, PREAMBLE, PAYLOAD, GAP);
  - `SEQ_PREAMBLE` = 4'b1011;
  - `SEQ_PRE_W` = 4.
- Sub-module `seq_stuff_tracker`: 3-bit history register plus the insert decision. It is instantiated only under the macro.

## Test plan
- Reset mid-payload:
  - Stimulus: assert `reset` during PAYLOAD.
  - Response: same cycle, `sequence_out`=0, `frame_active`=0, no `done`; after release, `data_ready`=1.
- Payload 0xA5, no macro:
  - Stream 1011 10100101 over 12 cycles, then `done` pulse.
  - `frame_active` high for exactly 12 cycles.
- Payload 0xA5, macro defined:
  - Stream 1011 101 0 00101 over 13 cycles.
  - `stuffed_bit`=1 only in cycle 8 of the frame.
  - Feeding the stream to the detector gives exactly one detection.
- Payload 0xFF and 0x00, macro defined:
  - No stuffing; frames of 12 cycles.
- Back-to-back, DATA_W=8, GAP_CYCLES=2, `data_valid` held high:
  - Preamble starts every 15 cycles.
  - `data_ready` low throughout each frame.
- `data_in` changed and `data_valid` toggled during a frame:
  - The transmitted payload equals the word latched at the accepting edge.
